// File: rtl/zpu_sdio_bridge.sv
// zpu_sdio_bridge: bridge between the ZPU drive firmware and the hps_io SD
// block-transfer interface for up to eight virtual drives.
//
// Owns the shared sector buffer, the LBA register, the per-drive block
// request FSM and a per-drive mount-event queue.
//
// Optional feature: define SDIO_TIMEOUT_EN to abort a transfer that stays in
// REQ/ACK for TIMEOUT_CYC cycles. The abort reports io_done=1 and io_err=1.
// Without the macro the FSM waits on sd_ack for as long as it takes.
//
// Ports:
//   clk_sys, areset        clock, synchronous active-high reset
//   lba_wr, cpu_data       ZPU loads sd_lba from cpu_data
//   data_wr/data_rd        ZPU buffer write/consume strobes at ptr
//   ptr_clr, rd_data       pointer clear, buffer byte at ptr (1-cycle latency)
//   blk_rd/blk_wr/drv_sel  block command, started on a rising edge
//   io_done, io_err        transfer idle, last command failed
//   mnt_*                  presented mount event and its pop strobe
//   sd_*                   hps_io block interface and buffer port
//   img_*                  hps_io mount pulses, read-only flag, image size
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no transfer; accepts block command edges
// REQ   | sd_rd/sd_wr raised, waiting for sd_ack high
// ACK   | hps is moving the sector, waiting for sd_ack low
module zpu_sdio_bridge #(
  parameter int              NDRV        = 4,
  parameter int              BUF_AW      = 9,
  parameter logic [NDRV-1:0] RO_MASK     = '0,
  parameter int              TIMEOUT_CYC = 16777216
) (
  input  logic              clk_sys,
  input  logic              areset,
  input  logic              lba_wr,
  input  logic [31:0]       cpu_data,
  input  logic              data_wr,
  input  logic              data_rd,
  input  logic              ptr_clr,
  output logic [7:0]        rd_data,
  input  logic              blk_rd,
  input  logic              blk_wr,
  input  logic [2:0]        drv_sel,
  output logic              io_done,
  output logic              io_err,
  output logic              mnt_valid,
  output logic [2:0]        mnt_drv,
  output logic              mnt_ro,
  output logic [31:0]       mnt_size,
  input  logic              mnt_ack,
  output logic [31:0]       sd_lba,
  output logic [NDRV-1:0]   sd_rd,
  output logic [NDRV-1:0]   sd_wr,
  input  logic              sd_ack,
  input  logic [BUF_AW-1:0] sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  output logic [7:0]        sd_buff_din,
  input  logic              sd_buff_wr,
  input  logic [NDRV-1:0]   img_mounted,
  input  logic              img_readonly,
  input  logic [31:0]       img_size
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] NDRV_L = 4'(NDRV);

  // ---------------------------------------------------------------- buffer
  logic [7:0]        mem [0:(1<<BUF_AW)-1];
  logic [BUF_AW-1:0] ptr;
  logic              zpu_we;

  // ptr_clr wins over data_wr, so a clear strobe also suppresses the write.
  assign zpu_we = data_wr & ~ptr_clr;

  always_ff @(posedge clk_sys) begin
    if (sd_buff_wr) mem[sd_buff_addr] <= sd_buff_dout;
    if (zpu_we)     mem[ptr]          <= cpu_data[7:0];
    sd_buff_din <= mem[sd_buff_addr];
    rd_data     <= mem[ptr];
  end

  always_ff @(posedge clk_sys) begin
    if (areset)                 ptr <= '0;
    else if (ptr_clr)           ptr <= '0;
    else if (data_wr | data_rd) ptr <= ptr + BUF_AW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (areset)      sd_lba <= '0;
    else if (lba_wr) sd_lba <= cpu_data;
  end

  // ------------------------------------------------------- edge detection
  logic            blk_rd_q, blk_wr_q;
  logic [NDRV-1:0] img_q;
  logic            rd_rise, wr_rise;
  logic [NDRV-1:0] mnt_rise;

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      blk_rd_q <= 1'b0;
      blk_wr_q <= 1'b0;
      img_q    <= '0;
    end else begin
      blk_rd_q <= blk_rd;
      blk_wr_q <= blk_wr;
      img_q    <= img_mounted;
    end
  end

  assign rd_rise  = blk_rd & ~blk_rd_q;
  assign wr_rise  = blk_wr & ~blk_wr_q;
  assign mnt_rise = img_mounted & ~img_q;

  // ------------------------------------------------------------ block FSM
  state_t          state, state_nxt;
  logic [2:0]      drv_q;
  logic            dir_wr_q;
  logic [NDRV-1:0] ro_lat;
  logic            start, start_wr, drv_bad, drv_ro, reject, accept;
  logic            timeout;

  assign start    = rd_rise | wr_rise;
  assign start_wr = wr_rise & ~rd_rise;
  assign drv_bad  = ({1'b0, drv_sel} >= NDRV_L);
  assign reject   = start & (drv_bad | (start_wr & drv_ro));
  assign accept   = start & ~reject;

  always_comb begin
    drv_ro = 1'b0;
    for (int i = 0; i < NDRV; i++)
      if (drv_sel == 3'(i)) drv_ro = RO_MASK[i] | ro_lat[i];
  end

`ifdef SDIO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Reloaded while idle, so every entry to REQ starts a fresh countdown.
  always_ff @(posedge clk_sys) begin
    if (areset)                 tmo_cnt <= '0;
    else if (state == S_IDLE)   tmo_cnt <= TW'(TIMEOUT_CYC - 1);
    else if (tmo_cnt != '0)     tmo_cnt <= tmo_cnt - TW'(1);
  end

  assign timeout = (state != S_IDLE) && (tmo_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)  state_nxt = S_REQ;
      S_REQ:   if (sd_ack)  state_nxt = S_ACK;
      S_ACK:   if (!sd_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  // Request lines are only up in REQ; the drive and direction are latched
  // on acceptance so drv_sel may change freely during a transfer.
  always_comb begin
    io_done = (state == S_IDLE);
    sd_rd   = '0;
    sd_wr   = '0;
    if (state == S_REQ) begin
      for (int i = 0; i < NDRV; i++) begin
        if (drv_q == 3'(i)) begin
          if (dir_wr_q) sd_wr[i] = 1'b1;
          else          sd_rd[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      drv_q    <= '0;
      dir_wr_q <= 1'b0;
      io_err   <= 1'b0;
    end else if (state == S_IDLE && start) begin
      if (reject) begin
        io_err <= 1'b1;
      end else begin
        io_err   <= 1'b0;
        drv_q    <= drv_sel;
        dir_wr_q <= start_wr;
      end
    end else if (timeout) begin
      io_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------- mount queue
  logic [NDRV-1:0] pending;
  logic [31:0]     size_lat [NDRV];
  logic [NDRV-1:0] pop_mask;
  logic [2:0]      sel_drv;
  logic            sel_ro;
  logic [31:0]     sel_size;
  logic            present;

  // Lowest pending index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    sel_drv  = '0;
    sel_ro   = 1'b0;
    sel_size = '0;
    pop_mask = '0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_drv  = 3'(i);
        sel_ro   = ro_lat[i];
        sel_size = size_lat[i];
        pop_mask = NDRV'(1) << i;
      end
    end
  end

  assign present = ~mnt_valid & ~mnt_ack & (|pending);

  // A mount edge on the drive being popped re-sets its bit after the clear,
  // so the new event is presented later with the freshly latched values.
  always_ff @(posedge clk_sys) begin
    if (areset) begin
      pending   <= '0;
      ro_lat    <= '0;
      mnt_valid <= 1'b0;
      mnt_drv   <= '0;
      mnt_ro    <= 1'b0;
      mnt_size  <= '0;
      for (int i = 0; i < NDRV; i++) size_lat[i] <= '0;
    end else begin
      pending <= (pending & ~(present ? pop_mask : '0)) | mnt_rise;
      for (int i = 0; i < NDRV; i++) begin
        if (mnt_rise[i]) begin
          size_lat[i] <= img_size;
          ro_lat[i]   <= img_readonly | RO_MASK[i];
        end
      end
      if (mnt_ack) begin
        mnt_valid <= 1'b0;
      end else if (present) begin
        mnt_valid <= 1'b1;
        mnt_drv   <= sel_drv;
        mnt_ro    <= sel_ro;
        mnt_size  <= sel_size;
      end
    end
  end

endmodule

// File: tb/tb_zpu_sdio_bridge.sv
module tb_zpu_sdio_bridge;
  localparam int         NDRV        = 4;
  localparam int         BUF_AW      = 9;
  localparam int         DEPTH       = 512;
  localparam logic [3:0] RO_MASK     = 4'b1000;
  localparam int         TIMEOUT_CYC = 100;

  logic              clk_sys = 1'b0;
  logic              areset;
  logic              lba_wr;
  logic [31:0]       cpu_data;
  logic              data_wr, data_rd, ptr_clr;
  logic [7:0]        rd_data;
  logic              blk_rd, blk_wr;
  logic [2:0]        drv_sel;
  logic              io_done, io_err;
  logic              mnt_valid;
  logic [2:0]        mnt_drv;
  logic              mnt_ro;
  logic [31:0]       mnt_size;
  logic              mnt_ack;
  logic [31:0]       sd_lba;
  logic [NDRV-1:0]   sd_rd, sd_wr;
  logic              sd_ack;
  logic [BUF_AW-1:0] sd_buff_addr;
  logic [7:0]        sd_buff_dout, sd_buff_din;
  logic              sd_buff_wr;
  logic [NDRV-1:0]   img_mounted;
  logic              img_readonly;
  logic [31:0]       img_size;

  always #5 clk_sys = ~clk_sys;

  zpu_sdio_bridge #(
    .NDRV(NDRV), .BUF_AW(BUF_AW), .RO_MASK(RO_MASK), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_sys(clk_sys), .areset(areset), .lba_wr(lba_wr), .cpu_data(cpu_data),
    .data_wr(data_wr), .data_rd(data_rd), .ptr_clr(ptr_clr), .rd_data(rd_data),
    .blk_rd(blk_rd), .blk_wr(blk_wr), .drv_sel(drv_sel), .io_done(io_done),
    .io_err(io_err), .mnt_valid(mnt_valid), .mnt_drv(mnt_drv), .mnt_ro(mnt_ro),
    .mnt_size(mnt_size), .mnt_ack(mnt_ack), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // reference model state
  logic [7:0]  mem_m [DEPTH];
  int          ptr_m;
  bit          zpu_chk;
  logic [3:0]  pend_m, img_prev_m, ro_m;
  logic        valid_m, ro_pres_m;
  logic [2:0]  drv_m;
  logic [31:0] size_pres_m;
  logic [31:0] size_m [4];
  logic        err_m;

  task automatic zpu_cycle(input bit clr, input bit wr, input bit rd, input logic [7:0] d);
    logic [7:0] exp;
    exp      = mem_m[ptr_m];
    ptr_clr  = clr;
    data_wr  = wr;
    data_rd  = rd;
    cpu_data = {24'h0, d};
    tick();
    ptr_clr = 0; data_wr = 0; data_rd = 0;
    if (clr) ptr_m = 0;
    else if (wr) begin
      mem_m[ptr_m] = d;
      ptr_m = (ptr_m + 1) % DEPTH;
    end else if (rd) ptr_m = (ptr_m + 1) % DEPTH;
    if (zpu_chk) check("rd_data", rd_data, exp);
  endtask

  task automatic hps_cycle(input bit we, input int addr, input logic [7:0] d);
    logic [7:0] exp;
    exp          = mem_m[addr];
    sd_buff_wr   = we;
    sd_buff_addr = addr[8:0];
    sd_buff_dout = d;
    tick();
    sd_buff_wr = 0;
    if (we) mem_m[addr] = d;
    check("sd_buff_din", sd_buff_din, exp);
  endtask

  task automatic mount_cycle(input logic [3:0] img, input logic [31:0] sz, input bit ro, input bit ack);
    logic [3:0] rise;
    bit         pres;
    int         j;
    rise = img & ~img_prev_m;
    pres = !valid_m && !ack && (pend_m != 0);
    img_mounted  = img;
    img_size     = sz;
    img_readonly = ro;
    mnt_ack      = ack;
    tick();
    mnt_ack = 0;
    if (ack) valid_m = 0;
    else if (pres) begin
      j = 0;
      for (int i = 3; i >= 0; i--) if (pend_m[i]) j = i;
      valid_m     = 1;
      drv_m       = j[2:0];
      ro_pres_m   = ro_m[j];
      size_pres_m = size_m[j];
      pend_m[j]   = 0;
    end
    pend_m = pend_m | rise;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        size_m[i] = sz;
        ro_m[i]   = ro | RO_MASK[i];
      end
    end
    img_prev_m = img;
    check("mnt_valid", mnt_valid, valid_m);
    if (valid_m) begin
      check("mnt_drv", mnt_drv, drv_m);
      check("mnt_ro", mnt_ro, ro_pres_m);
      check("mnt_size", mnt_size, size_pres_m);
    end
  endtask

  // dir: 0 read, 1 write, 2 both edges together (read wins)
  task automatic blk_cmd(input int drv, input int dir, input logic [31:0] lba,
                         input int delay, input int alen);
    bit         is_wr, bad;
    logic [3:0] onehot;
    lba_wr = 1; cpu_data = lba;
    tick();
    lba_wr = 0;
    check("sd_lba", sd_lba, lba);
    is_wr = (dir == 1);
    if (drv >= NDRV) bad = 1;
    else bad = is_wr && (RO_MASK[drv] || ro_m[drv]);
    onehot  = bad ? 4'b0000 : (4'b0001 << drv);
    drv_sel = drv[2:0];
    blk_rd  = (dir != 1);
    blk_wr  = (dir != 0);
    tick();
    if (bad) begin
      err_m = 1;
      check("rej_sd_rd", sd_rd, 0);
      check("rej_sd_wr", sd_wr, 0);
      check("rej_io_done", io_done, 1);
      check("rej_io_err", io_err, err_m);
    end else begin
      err_m = 0;
      check("req_sd_rd", sd_rd, is_wr ? 4'b0000 : onehot);
      check("req_sd_wr", sd_wr, is_wr ? onehot : 4'b0000);
      check("req_io_done", io_done, 0);
      check("req_io_err", io_err, err_m);
      for (int k = 0; k < delay; k++) begin
        drv_sel = 3'($urandom_range(0, 7));
        blk_rd  = (k != 0);
        blk_wr  = (k != 0);
        tick();
        check("hold_sd_rd", sd_rd, is_wr ? 4'b0000 : onehot);
        check("hold_sd_wr", sd_wr, is_wr ? onehot : 4'b0000);
      end
      sd_ack = 1;
      for (int k = 0; k < alen; k++) begin
        tick();
        check("ack_io_done", io_done, 0);
        if (k == 0) begin
          check("ack_sd_rd", sd_rd, 0);
          check("ack_sd_wr", sd_wr, 0);
        end
      end
      sd_ack = 0;
      tick();
      check("done_io_done", io_done, 1);
      check("done_io_err", io_err, err_m);
      check("done_sd_rd", sd_rd, 0);
      tick();
      check("idle_stay", io_done, 1);
    end
    blk_rd = 0; blk_wr = 0;
    tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sd_lba"}, sd_lba, 0);
    check({pfx, "_sd_rd"}, sd_rd, 0);
    check({pfx, "_sd_wr"}, sd_wr, 0);
    check({pfx, "_io_done"}, io_done, 1);
    check({pfx, "_io_err"}, io_err, 0);
    check({pfx, "_mnt_valid"}, mnt_valid, 0);
    check({pfx, "_mnt_drv"}, mnt_drv, 0);
    check({pfx, "_mnt_ro"}, mnt_ro, 0);
    check({pfx, "_mnt_size"}, mnt_size, 0);
  endtask

  initial begin
    logic [7:0] first_b;
    areset = 1; lba_wr = 0; cpu_data = 0; data_wr = 0; data_rd = 0; ptr_clr = 0;
    blk_rd = 0; blk_wr = 0; drv_sel = 0; mnt_ack = 0; sd_ack = 0;
    sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
    img_mounted = 0; img_readonly = 0; img_size = 0;
    zpu_chk = 0; ptr_m = 0; pend_m = 0; img_prev_m = 0; ro_m = 0;
    valid_m = 0; ro_pres_m = 0; drv_m = 0; size_pres_m = 0; err_m = 0;
    for (int i = 0; i < 4; i++) size_m[i] = 0;
    tick(); tick();
    check_reset_outputs("reset");
    areset = 0;
    tick();

    // mount queue: two drives mounted in the same cycle
    mount_cycle(4'b0110, 32'h16810, 0, 0);
    mount_cycle(4'b0000, 0, 0, 0);
    check("plan_first_drv", mnt_drv, 1);
    check("plan_first_size", mnt_size, 32'h16810);
    mount_cycle(4'b0000, 0, 0, 1);
    mount_cycle(4'b0000, 0, 0, 0);
    check("plan_second_drv", mnt_drv, 2);
    mount_cycle(4'b0000, 0, 0, 1);
    mount_cycle(4'b0000, 0, 0, 0);
    check("plan_drained", mnt_valid, 0);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] img;
      img = 0;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) img[i] = 1;
      mount_cycle(img, $urandom, 1'($urandom_range(0, 1)),
                  valid_m && ($urandom_range(0, 1) == 1));
    end
    for (int n = 0; n < 40; n++) mount_cycle(4'b0000, 0, 0, valid_m);
    check("mnt_final_drain", mnt_valid, 0);

    // fill the whole buffer; 512 writes bring ptr back to 0
    for (int a = 0; a < DEPTH; a++) zpu_cycle(0, 1, 0, 8'($urandom));
    first_b = mem_m[0];
    zpu_chk = 1;
    zpu_cycle(0, 0, 0, 0);
    check("wrap_rd", rd_data, first_b);

    zpu_cycle(1, 0, 0, 0);
    zpu_cycle(0, 1, 0, 8'h11);
    zpu_cycle(0, 1, 0, 8'h22);
    zpu_cycle(0, 1, 0, 8'h33);
    zpu_cycle(1, 0, 0, 0);
    zpu_cycle(0, 0, 0, 0);
    check("plan_rd0", rd_data, 8'h11);
    zpu_cycle(0, 0, 1, 0);
    zpu_cycle(0, 0, 0, 0);
    check("plan_rd1", rd_data, 8'h22);
    zpu_cycle(0, 0, 1, 0);
    zpu_cycle(0, 0, 0, 0);
    check("plan_rd2", rd_data, 8'h33);

    for (int n = 0; n < 300; n++)
      zpu_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                1'($urandom_range(0, 1)), 8'($urandom));

    // hps <-> ZPU through the shared buffer
    hps_cycle(1, 7, 8'hA5);
    zpu_cycle(1, 0, 0, 0);
    for (int k = 0; k < 7; k++) zpu_cycle(0, 0, 1, 0);
    zpu_cycle(0, 0, 0, 0);
    check("plan_hps_to_zpu", rd_data, 8'hA5);
    zpu_cycle(0, 1, 0, 8'h5C);
    hps_cycle(0, 7, 0);
    check("plan_zpu_to_hps", sd_buff_din, 8'h5C);
    for (int n = 0; n < 100; n++)
      hps_cycle(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 8'($urandom));

    // block commands
    blk_cmd(2, 0, 32'h00001234, 3, 10);
    blk_cmd(3, 1, 32'h00000042, 1, 1);
    blk_cmd(5, 0, 32'h00000043, 1, 1);
    blk_cmd(1, 2, 32'h00000044, 2, 2);
    for (int n = 0; n < 40; n++)
      blk_cmd($urandom_range(0, 5), $urandom_range(0, 2), $urandom,
              $urandom_range(1, 6), $urandom_range(1, 5));

    // sd_ack never comes, then reset in the middle of a request
    drv_sel = 0; blk_rd = 1;
    tick();
    check("tmo_start", sd_rd, 4'b0001);
    for (int k = 1; k < TIMEOUT_CYC; k++) tick();
    check("tmo_before", sd_rd, 4'b0001);
    tick();
`ifdef SDIO_TIMEOUT_EN
    check("tmo_sd_rd", sd_rd, 0);
    check("tmo_io_done", io_done, 1);
    check("tmo_io_err", io_err, 1);
    blk_rd = 0;
    tick();
    blk_rd = 1;
    tick();
`else
    check("no_tmo_sd_rd", sd_rd, 4'b0001);
    check("no_tmo_io_done", io_done, 0);
`endif
    mount_cycle(4'b0001, 32'h0000ABCD, 1, 0);
    mount_cycle(4'b0000, 0, 0, 0);
    check("pre_reset_busy", io_done, 0);
    areset = 1; blk_rd = 0;
    tick();
    areset = 0;
    check_reset_outputs("midreq");
    tick();
    check("reset_ptr", rd_data, mem_m[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/zpu_sdio_bridge.md
Name:
zpu_sdio_bridge

Overview:
- Multi-drive bridge between the ZPU drive firmware and the hps_io SD block-transfer interface.
- Owns the shared sector buffer, the LBA register and the per-drive read/write request FSM.
- Queues image-mount events so that simultaneous or back-to-back mounts are never lost.
- Successor to the fixed 3-drive glue logic: parametrised in drive count, buffer depth and read-only mask; adds error reporting and a mount queue.

Parameters:
- NDRV, 4, number of virtual drives (1..8); width of sd_rd, sd_wr, img_mounted.
- BUF_AW, 9, sector buffer address width; buffer holds 2^BUF_AW bytes.
- RO_MASK, 0, NDRV-bit mask of drives that are always read-only (e.g. the cart slot).
- TIMEOUT_CYC, 16777216, abort threshold in clk_sys cycles (used only with SDIO_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock
- areset  in  1  synchronous, active-high reset
- lba_wr  in  1  one-cycle strobe: sd_lba <= cpu_data
- cpu_data  in  32  write data from ZPU
- data_wr  in  1  one-cycle strobe: write cpu_data[7:0] at ptr, then ptr++
- data_rd  in  1  one-cycle strobe: ptr++ (consume current byte)
- ptr_clr  in  1  one-cycle strobe: ptr <= 0
- rd_data  out  8  buffer byte at ptr
- blk_rd  in  1  level; rising edge starts a sector read
- blk_wr  in  1  level; rising edge starts a sector write
- drv_sel  in  3  target drive of the block command
- io_done  out  1  no transfer in progress
- io_err  out  1  last command failed
- mnt_valid  out  1  mount event presented
- mnt_drv  out  3  drive of the presented event
- mnt_ro  out  1  presented drive is read-only
- mnt_size  out  32  image size of the presented drive
- mnt_ack  in  1  one-cycle strobe: pop the presented event
- sd_lba  out  32  to hps_io
- sd_rd  out  NDRV  to hps_io
- sd_wr  out  NDRV  to hps_io
- sd_ack  in  1  from hps_io
- sd_buff_addr  in  BUF_AW  from hps_io
- sd_buff_dout  in  8  from hps_io
- sd_buff_din  out  8  to hps_io
- sd_buff_wr  in  1  from hps_io
- img_mounted  in  NDRV  from hps_io, per-drive mount pulses
- img_readonly  in  1  from hps_io
- img_size  in  32  from hps_io (low 32 bits)

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, ptr=0, io_done=1, io_err=0, mnt_valid=0, mnt_drv=0, mnt_ro=0, mnt_size=0, pending=0, FSM=IDLE. Reset in any state aborts the transfer immediately.
- Buffer: true dual-port RAM, 2^BUF_AW x 8.
  - Port A is hps (sd_buff_*); sd_buff_din has 1-cycle read latency.
  - Port B is the ZPU side.
- Pointer ptr (BUF_AW bits):
  - rd_data = buf[ptr], valid 1 cycle after ptr changes.
  - data_wr writes at the current ptr and increments ptr on the same edge.
  - data_rd increments ptr.
  - Wraps 2^BUF_AW-1 -> 0.
  - Priority: ptr_clr > data_wr > data_rd; one increment per cycle maximum.
- lba_wr loads sd_lba in any FSM state. A mid-transfer load is the firmware's responsibility.
- FSM states: IDLE, REQ, ACK.
  - IDLE, rising edge of blk_rd or blk_wr (edge registered internally):
    - drv_sel >= NDRV: io_err=1, stay IDLE.
    - Write to a read-only drive (RO_MASK bit set, or last mount of that drive had ro): io_err=1, stay IDLE.
    - Otherwise: set sd_rd[drv_sel] or sd_wr[drv_sel], io_done=0, io_err=0, go to REQ.
    - blk_rd takes priority if both edges occur in the same cycle.
  - REQ: on sd_ack=1, clear all of sd_rd and sd_wr; go to ACK.
  - ACK: on sd_ack=0, io_done=1; go to IDLE.
  - Block edges arriving in REQ or ACK are ignored (not queued).
- Mount queue:
  - A rising edge of img_mounted[i] sets pending[i] and latches size[i]=img_size and ro[i]=img_readonly|RO_MASK[i].
  - A re-mount while pending overwrites size[i] and ro[i]. There is one entry per drive, so nothing is lost.
  - Presenter: when mnt_valid=0 and pending!=0, select the lowest set index, drive mnt_* from it, set mnt_valid=1 and clear that pending bit. Latency is 1 cycle after the pending bit sets.
  - mnt_ack clears mnt_valid. The next event is presented no earlier than the following cycle.
  - A new mount edge coinciding with a pop or present is never lost.

Optional Feature:
- Macro: SDIO_TIMEOUT_EN.
- With the macro: a counter runs in REQ and ACK. On reaching TIMEOUT_CYC, clear sd_rd and sd_wr, set io_done=1 and io_err=1, and go to IDLE. The counter resets on every entry to REQ.
- Without the macro: no counter and no timeout; the FSM waits on sd_ack indefinitely, and TIMEOUT_CYC is unused.

Test Plan:
- ptr_clr, then data_wr of 0x11, 0x22, 0x33, ptr_clr, three data_rd strobes -> rd_data reads 0x11, 0x22, 0x33; 512 writes (BUF_AW=9) wrap ptr to 0.
- lba_wr 0x00001234, blk_rd rising with drv_sel=2 -> sd_lba=0x1234, sd_rd=4'b0100, io_done=0.
  - sd_ack high for 10 cycles -> sd_rd=0 on the first ack cycle.
  - sd_ack low -> io_done=1 next cycle.
- hps writes 0xA5 at sd_buff_addr 7 during the ack window; ZPU sets ptr=7 -> rd_data=0xA5. The reverse direction (ZPU writes, hps reads) matches likewise.
- RO_MASK=4'b1000, blk_wr with drv_sel=3 -> sd_wr stays 0, io_err=1, io_done=1. drv_sel=5 with NDRV=4 -> io_err=1.
- img_mounted=4'b0110 in one cycle, sizes 0x16810 -> mnt_valid presents drive 1. mnt_ack -> drive 2 presented. Second mnt_ack -> mnt_valid=0.
- With SDIO_TIMEOUT_EN and TIMEOUT_CYC=100, blk_rd with sd_ack never asserted -> at cycle 100 sd_rd=0, io_done=1, io_err=1. areset mid-REQ -> all outputs return to reset values next cycle.
